// File: rtl/ram8_bank.sv
// Eight-word register bank feeding the RAM8 read mux, with a one-word-per-cycle
// clear sweep engine and a per-word dirty map.
module ram8_bank #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clr_req,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [7:0]       dirty
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [WIDTH-1:0] words [8];
  logic [0:0]       state;
  logic [2:0]       counter;

  // A clear request in IDLE beats a simultaneous load; while sweeping, both are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        words[i] <= '0;
      end
      dirty   <= 8'h00;
      busy    <= 1'b0;
      state   <= IDLE;
      counter <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            counter <= 3'd0;
            busy    <= 1'b1;
          end else if (load) begin
            words[address] <= in;
            dirty[address] <= 1'b1;
          end
        end
        CLEAR: begin
          words[counter] <= CLR_VALUE;
          dirty[counter] <= 1'b0;
          if (counter == 3'd7) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= 3'd0;
          end else begin
            counter <= counter + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out = words[address];

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank: vector table plus hand-written sweep,
// collision and mid-sweep reset sequences, checked through an expectation queue.
module tb_ram8_bank;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [2:0]  address;
  logic        load;
  logic        clr_req;
  logic [15:0] dout;
  logic        busy;
  logic [7:0]  dirty;

  typedef struct {
    logic        load;
    logic [2:0]  address;
    logic [15:0] din;
    logic        clr;
    logic [15:0] eout;
    logic [7:0]  edirty;
    logic        ebusy;
  } vec_t;

  typedef struct {
    logic [15:0] eout;
    logic [7:0]  edirty;
    logic        ebusy;
  } exp_t;

  exp_t expq[$];
  vec_t tbl[9];
  int   nTests;
  int   nFail;

  ram8_bank #(.WIDTH(16), .CLR_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset), .in(din), .address(address), .load(load),
    .clr_req(clr_req), .out(dout), .busy(busy), .dirty(dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string nm);
    exp_t e;
    if (expq.size() == 0) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL %s: scoreboard empty, got 1 expected 0 missing entries", nm);
    end else begin
      e = expq.pop_front();
      compare({nm, "_out"}, dout, e.eout);
      compare({nm, "_dirty"}, {8'h00, dirty}, {8'h00, e.edirty});
      compare({nm, "_busy"}, {15'h0, busy}, {15'h0, e.ebusy});
    end
  endtask

  // Drive one edge worth of inputs, queue its expected result, check after the edge.
  task automatic applyStimulus(input vec_t v, input string nm);
    exp_t e;
    load    = v.load;
    address = v.address;
    din     = v.din;
    clr_req = v.clr;
    e.eout   = v.eout;
    e.edirty = v.edirty;
    e.ebusy  = v.ebusy;
    expq.push_back(e);
    @(posedge clk);
    #1;
    load    = 1'b0;
    clr_req = 1'b0;
    checkOutput(nm);
  endtask

  task automatic checkRead(input logic [2:0] a, input logic [15:0] exp, input string nm);
    address = a;
    #1;
    compare(nm, dout, exp);
  endtask

  task automatic makeVec(input logic ld, input logic [2:0] a, input logic [15:0] d,
                         input logic c, input logic [15:0] eo, input logic [7:0] ed,
                         input logic eb, output vec_t v);
    v.load = ld; v.address = a; v.din = d; v.clr = c;
    v.eout = eo; v.edirty = ed; v.ebusy = eb;
  endtask

  initial begin
    vec_t       v;
    logic [7:0] ed;
    nTests  = 0;
    nFail   = 0;
    reset   = 1'b1;
    din     = 16'h0;
    address = 3'd0;
    load    = 1'b0;
    clr_req = 1'b0;

    makeVec(1, 3'd5, 16'hBEEF, 0, 16'hBEEF, 8'h20, 0, tbl[0]);
    makeVec(1, 3'd0, 16'h1000, 0, 16'h1000, 8'h21, 0, tbl[1]);
    makeVec(1, 3'd1, 16'h1001, 0, 16'h1001, 8'h23, 0, tbl[2]);
    makeVec(1, 3'd2, 16'h1002, 0, 16'h1002, 8'h27, 0, tbl[3]);
    makeVec(1, 3'd3, 16'h1003, 0, 16'h1003, 8'h2F, 0, tbl[4]);
    makeVec(1, 3'd4, 16'h1004, 0, 16'h1004, 8'h3F, 0, tbl[5]);
    makeVec(1, 3'd5, 16'h1005, 0, 16'h1005, 8'h3F, 0, tbl[6]);
    makeVec(1, 3'd6, 16'h1006, 0, 16'h1006, 8'h7F, 0, tbl[7]);
    makeVec(1, 3'd7, 16'h1007, 0, 16'h1007, 8'hFF, 0, tbl[8]);

    repeat (2) @(posedge clk);
    #1;
    compare("reset_busy", {15'h0, busy}, 16'h0000);
    compare("reset_dirty", {8'h00, dirty}, 16'h0000);
    for (int i = 0; i < 8; i++) checkRead(3'(i), 16'h0000, "reset_read");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write, then the table fill.
    applyStimulus(tbl[0], "write_beef");
    checkRead(3'd4, 16'h0000, "beef_neighbor4");
    checkRead(3'd6, 16'h0000, "beef_neighbor6");
    for (int i = 1; i < 9; i++) applyStimulus(tbl[i], "fill");
    for (int i = 0; i < 8; i++) checkRead(3'(i), 16'h1000 + 16'(i), "fill_read");

    // Full sweep with dropped loads and an ignored re-request on edge 3.
    makeVec(0, 3'd3, 16'h0, 1, 16'h1003, 8'hFF, 1, v);
    applyStimulus(v, "clr_start");
    for (int k = 1; k <= 8; k++) begin
      ed = 8'hFF << k;
      makeVec(1, 3'd3, 16'hFFFF, (k == 3), (k >= 4) ? 16'h0000 : 16'h1003, ed, (k < 8), v);
      applyStimulus(v, "sweep");
    end
    for (int i = 0; i < 8; i++) checkRead(3'(i), 16'h0000, "sweep_read");

    // Clear and load on the same edge: clear wins.
    makeVec(1, 3'd2, 16'h5555, 0, 16'h5555, 8'h04, 0, v);
    applyStimulus(v, "pre_collide");
    makeVec(1, 3'd2, 16'h1234, 1, 16'h5555, 8'h04, 1, v);
    applyStimulus(v, "collide");
    for (int k = 1; k <= 8; k++) begin
      makeVec(0, 3'd2, 16'h0, 0, (k >= 3) ? 16'h0000 : 16'h5555,
              (k >= 3) ? 8'h00 : 8'h04, (k < 8), v);
      applyStimulus(v, "collide_sweep");
    end
    makeVec(1, 3'd6, 16'hABCD, 0, 16'hABCD, 8'h40, 0, v);
    applyStimulus(v, "ninth_edge_write");

    // Reset during the fourth sweep cycle.
    makeVec(1, 3'd1, 16'h1111, 0, 16'h1111, 8'h42, 0, v);
    applyStimulus(v, "pre6_w1");
    makeVec(1, 3'd7, 16'h7777, 0, 16'h7777, 8'hC2, 0, v);
    applyStimulus(v, "pre6_w7");
    makeVec(0, 3'd7, 16'h0, 1, 16'h7777, 8'hC2, 1, v);
    applyStimulus(v, "mid_clr_start");
    makeVec(0, 3'd7, 16'h0, 0, 16'h7777, 8'hC2, 1, v);
    applyStimulus(v, "mid_k1");
    makeVec(0, 3'd7, 16'h0, 0, 16'h7777, 8'hC0, 1, v);
    applyStimulus(v, "mid_k2");
    makeVec(0, 3'd7, 16'h0, 0, 16'h7777, 8'hC0, 1, v);
    applyStimulus(v, "mid_k3");
    #2;
    reset = 1'b1;
    #1;
    compare("midreset_busy", {15'h0, busy}, 16'h0000);
    compare("midreset_dirty", {8'h00, dirty}, 16'h0000);
    for (int i = 0; i < 8; i++) checkRead(3'(i), 16'h0000, "midreset_read");
    @(posedge clk);
    #1;
    reset = 1'b0;
    makeVec(1, 3'd7, 16'h7E57, 0, 16'h7E57, 8'h80, 0, v);
    applyStimulus(v, "post_reset_w7");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
